wb_spi_bridge: RTL and testbench
================================

// Module: wb_spi_bridge
// PURPOSE
// - Wishbone slave (WB MI A) that lets the management SoC drive rapcore's SPI command port (SCK/CS/COPI/CIPO) from firmware.
// - Sits upstream of rapcore inside rapcore_caravel; its SPI outputs are muxed with io_in[35:33] by the wrapper.
// - Full-duplex, SPI mode 0, MSB first, XFER_BITS per CS frame; answers wbs_ack_o, which the wrapper leaves undriven today.
// PARAMETERS
// - BASE_ADDR  32'h3000_0000  Wishbone base; decode on wbs_adr_i[31:5]==BASE_ADDR[31:5].
// - XFER_BITS  64             bits per CS-low frame; legal values 32 or 64.
// - DIV_RST    8'd3           reset value of CTRL.DIV.
// PORTS
// - wb_clk_i    in   1   system clock; all logic on its rising edge.
// - resetn      in   1   synchronous, active-low reset.
// - wbs_stb_i   in   1   Wishbone strobe.
// - wbs_cyc_i   in   1   Wishbone cycle.
// - wbs_we_i    in   1   write enable.
// - wbs_sel_i   in   4   byte lanes; write lanes only where the sel bit is 1.
// - wbs_adr_i   in   32  byte address.
// - wbs_dat_i   in   32  write data.
// - wbs_ack_o   out  1   single-cycle acknowledge.
// - wbs_dat_o   out  32  read data; valid while ack is high, 0 otherwise.
// - spi_sck_o   out  1   SPI clock; idles low.
// - spi_cs_o    out  1   chip select, active low; idles high.
// - spi_copi_o  out  1   controller-out data.
// - spi_cipo_i  in   1   controller-in data; sampled on the SCK rising edge.
// - busy_o      out  1   high from START until CS deasserts.
// - irq_o       out  1   level interrupt: STATUS.DONE & CTRL.IE.
// BEHAVIOUR
// - Register map (offset):
//   - 0x00 CTRL: [7:0] DIV, [8] IE, [9] START (write-1, reads 0).
//   - 0x04 STATUS: [0] BUSY, [1] DONE (sticky, W1C), [2] ERR (sticky, W1C).
//   - 0x08 TX_LO, 0x0C TX_HI, 0x10 RX_LO (RO), 0x14 RX_HI (RO).
//   - The HI registers exist only when XFER_BITS==64; otherwise they read 0 and ignore writes.
//   - Unmapped offsets read 0, ignore writes and are still acked.
// - Wishbone handshake:
//   - valid = cyc & stb & address hit.
//   - ack rises on the cycle after valid and stays high for exactly 1 cycle.
//   - A new ack is not issued until valid has dropped (no double ack on a held strobe).
// - Reset values:
//   - ack=0, dat_o=0, sck=0, cs=1, copi=0, busy=0, irq=0.
//   - CTRL.DIV=DIV_RST, IE=0; TX=0, RX=0, DONE=0, ERR=0.
// - FSM states IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Half-period H = DIV+1 clocks.
//   - IDLE: START=1 latches TX into the shift register and loads bitcnt=XFER_BITS; cs=0, copi=MSB -> SETUP.
//   - SETUP: wait H -> SHIFT.
//   - SHIFT: SCK toggles every H clocks.
//     - Rising edge: shift spi_cipo_i into RX shift LSB.
//     - Falling edge: present the next COPI bit, decrement bitcnt.
//     - After the last rising edge plus H, sck=0 -> HOLD.
//   - HOLD: wait H; then cs=1, RX registers updated, DONE=1 -> IDLE.
// - Latency: START ack to CS high = (2*XFER_BITS+2)*H + 1 clocks.
// - Boundary conditions:
//   - START, or a write to TX, while BUSY: ignored, ERR=1, still acked.
//   - START and a TX write in the same access are impossible (different offsets).
//   - W1C of DONE on the same cycle that DONE is set: set wins.
//   - DIV=0 gives H=1, i.e. SCK = wb_clk_i/2.
//   - DIV changes mid-frame: ignored; DIV is latched at START.
//   - resetn low mid-frame: next clock cs=1, sck=0, FSM=IDLE; RX keeps its reset value 0.
//   - RX reads during a frame return the previous frame's data.
// STRUCTURE
// - Shared package wb_spi_pkg:
//   - register offset localparams;
//   - CTRL/STATUS bit indices;
//   - FSM state encoding (2-bit enum).
// - One sub-module, spi_shift_engine: FSM, divider and shift registers.
// - The top level holds Wishbone decode and the register file.
// TESTING
// - Reset: hold resetn=0 for 3 clocks -> cs=1, sck=0, ack=0; STATUS reads 0; CTRL reads 0x003.
// - Loopback (copi tied to cipo), DIV=0, TX=64'hDEADBEEF_01234567, START
//   -> 128 SCK edges; RX = TX; DONE=1; total 131 clocks.
// - Write TX_LO during BUSY -> ERR=1; TX unchanged; frame completes normally; W1C of ERR clears it.
// - Hold stb for 5 cycles -> exactly one ack, 1 cycle after valid.
// - wbs_sel_i=4'b0010 write of 0xFFFFFFFF to TX_LO -> only bits [15:8] change.
// - IE=1 frame -> irq rises with DONE; write 0x2 to STATUS -> irq falls next cycle.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Shared definitions for the Wishbone-to-SPI bridge: register offsets,
// CTRL/STATUS bit positions, shift-engine state encoding and a byte-lane helper.
package wb_spi_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_TX_LO  = 5'h08;
  localparam logic [4:0] OFF_TX_HI  = 5'h0C;
  localparam logic [4:0] OFF_RX_LO  = 5'h10;
  localparam logic [4:0] OFF_RX_HI  = 5'h14;

  localparam int CTRL_IE_BIT    = 8;
  localparam int CTRL_START_BIT = 9;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Merge new_val into old_val only on byte lanes whose select bit is set.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: one CS-low frame of XFER_BITS bits, MSB first,
// full duplex. Half-period is DIV+1 clocks with DIV captured at start.
// The current FSM state is exported for observation.
module spi_shift_engine
  import wb_spi_pkg::*;
#(
  parameter int XFER_BITS = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [7:0]           div,
  input  logic [XFER_BITS-1:0] tx_data,
  input  logic                 cipo,
  output logic                 sck,
  output logic                 cs,
  output logic                 copi,
  output logic                 done,
  output logic [XFER_BITS-1:0] rx_data,
  output spi_state_e           state
);

  localparam int BCW = $clog2(XFER_BITS + 1);

  spi_state_e           state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [7:0]           hcnt_q, hcnt_d;
  logic [BCW-1:0]       bitcnt_q, bitcnt_d;
  logic [XFER_BITS-1:0] tx_q, tx_d;
  logic [XFER_BITS-1:0] rx_q, rx_d;
  logic                 sck_q, sck_d;
  logic                 cs_q, cs_d;
  logic                 copi_q, copi_d;
  logic                 half_tick;

  assign half_tick = (hcnt_q == div_q);
  assign sck       = sck_q;
  assign cs        = cs_q;
  assign copi      = copi_q;
  assign rx_data   = rx_q;
  assign state     = state_q;

  // Next-state and datapath: each half period either raises SCK (sample CIPO)
  // or lowers it (advance COPI, count the bit).
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    hcnt_d   = '0;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    copi_d   = copi_q;
    done     = 1'b0;
    if (state_q != ST_IDLE) begin
      hcnt_d = half_tick ? 8'd0 : hcnt_q + 8'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          div_d    = div;
          tx_d     = tx_data;
          rx_d     = '0;
          bitcnt_d = BCW'(XFER_BITS);
          cs_d     = 1'b0;
          copi_d   = tx_data[XFER_BITS-1];
        end
      end
      ST_SETUP: begin
        if (half_tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (half_tick) begin
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[XFER_BITS-2:0], cipo};
          end else begin
            sck_d    = 1'b0;
            bitcnt_d = bitcnt_q - BCW'(1);
            tx_d     = {tx_q[XFER_BITS-2:0], 1'b0};
            copi_d   = tx_q[XFER_BITS-2];
            if (bitcnt_q == BCW'(1)) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (half_tick) begin
          state_d = ST_IDLE;
          cs_d    = 1'b1;
          copi_d  = 1'b0;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      hcnt_q   <= '0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      copi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      copi_q   <= copi_d;
    end
  end

endmodule

// File: rtl/wb_spi_bridge.sv
// Wishbone slave exposing CTRL/STATUS/TX/RX registers that drive an SPI
// shift engine. Handshake: an access is accepted when cyc & stb & address
// hit are high and no ack has yet been given for this strobe; the ack is a
// registered one-cycle pulse with read data valid only while ack is high,
// and the strobe must drop before the next access is accepted.
module wb_spi_bridge
  import wb_spi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          XFER_BITS = 64,
  parameter logic [7:0]  DIV_RST   = 8'd3
) (
  input  logic        wb_clk_i,
  input  logic        resetn,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        busy_o,
  output logic        irq_o
);

  localparam bit HAS_HI = (XFER_BITS == 64);

  logic                 valid, access, wr, served_q, ack_q, start_q;
  logic [4:0]           off;
  logic [31:0]          dat_q, rdata;
  logic [7:0]           div_q;
  logic                 ie_q, done_q, err_q;
  logic [31:0]          tx_lo_q, tx_hi_q, rx_lo_q, rx_hi_q;
  logic                 busy, start_req, tx_wr, err_set;
  logic                 eng_done;
  logic [XFER_BITS-1:0] eng_rx;
  logic [63:0]          tx_full, rx_ext;
  spi_state_e           eng_state;

  assign off       = wbs_adr_i[4:0] & 5'b11100;
  assign valid     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign access    = valid & ~served_q;
  assign wr        = access & wbs_we_i;
  assign busy      = start_q | (eng_state != ST_IDLE);
  assign start_req = wr & (off == OFF_CTRL) & wbs_sel_i[1] & wbs_dat_i[CTRL_START_BIT];
  assign tx_wr     = wr & ((off == OFF_TX_LO) | ((off == OFF_TX_HI) & HAS_HI));
  assign err_set   = busy & (start_req | tx_wr);
  assign tx_full   = {tx_hi_q, tx_lo_q};
  assign rx_ext    = 64'(eng_rx);

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign busy_o    = busy;
  assign irq_o     = done_q & ie_q;

  // Read mux over the register map; unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata = {22'd0, 1'b0, ie_q, div_q};
      OFF_STATUS: rdata = {29'd0, err_q, done_q, busy};
      OFF_TX_LO:  rdata = tx_lo_q;
      OFF_TX_HI:  rdata = tx_hi_q;
      OFF_RX_LO:  rdata = rx_lo_q;
      OFF_RX_HI:  rdata = rx_hi_q;
      default:    rdata = '0;
    endcase
  end

  // Handshake, register file and status flags; frame completion beats a
  // same-cycle W1C of DONE.
  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      served_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      start_q  <= 1'b0;
      div_q    <= DIV_RST;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tx_lo_q  <= '0;
      tx_hi_q  <= '0;
      rx_lo_q  <= '0;
      rx_hi_q  <= '0;
    end else begin
      served_q <= valid & (served_q | access);
      ack_q    <= access;
      dat_q    <= (access & ~wbs_we_i) ? rdata : 32'd0;
      start_q  <= start_req & ~busy;
      if (wr && off == OFF_CTRL) begin
        if (wbs_sel_i[0]) div_q <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) ie_q  <= wbs_dat_i[CTRL_IE_BIT];
      end
      if (tx_wr && !busy) begin
        if (off == OFF_TX_LO) tx_lo_q <= apply_sel(tx_lo_q, wbs_dat_i, wbs_sel_i);
        else                  tx_hi_q <= apply_sel(tx_hi_q, wbs_dat_i, wbs_sel_i);
      end
      if (eng_done) begin
        done_q <= 1'b1;
      end else if (wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_DONE_BIT]) begin
        done_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_ERR_BIT]) begin
        err_q <= 1'b0;
      end
      if (eng_done) begin
        rx_lo_q <= rx_ext[31:0];
        rx_hi_q <= HAS_HI ? rx_ext[63:32] : 32'd0;
      end
    end
  end

  spi_shift_engine #(
    .XFER_BITS(XFER_BITS)
  ) u_engine (
    .clk    (wb_clk_i),
    .resetn (resetn),
    .start  (start_q),
    .div    (div_q),
    .tx_data(tx_full[XFER_BITS-1:0]),
    .cipo   (spi_cipo_i),
    .sck    (spi_sck_o),
    .cs     (spi_cs_o),
    .copi   (spi_copi_o),
    .done   (eng_done),
    .rx_data(eng_rx),
    .state  (eng_state)
  );

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Self-checking bench for wb_spi_bridge: Wishbone driver tasks, a register
// reference model, an SPI peripheral model and an ack-driven scoreboard.
module tb_wb_spi_bridge;

  localparam int          N    = 64;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_TXLO = BASE + 32'h08, A_TXHI = BASE + 32'h0C;
  localparam logic [31:0] A_RXLO = BASE + 32'h10, A_RXHI = BASE + 32'h14;

  // ---------------- clock / reset / DUT ----------------
  logic        wb_clk_i = 1'b0;
  logic        resetn = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        spi_sck_o, spi_cs_o, spi_copi_o, spi_cipo_i;
  logic        busy_o, irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_spi_bridge dut (
    .wb_clk_i  (wb_clk_i),
    .resetn    (resetn),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .spi_sck_o (spi_sck_o),
    .spi_cs_o  (spi_cs_o),
    .spi_copi_o(spi_copi_o),
    .spi_cipo_i(spi_cipo_i),
    .busy_o    (busy_o),
    .irq_o     (irq_o)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // bit 32 = read (data compared), [31:0] = expected data

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (register-level view) ----------------
  logic [7:0]  m_div, m_lat_div;
  logic        m_ie, m_done, m_err, m_active;
  logic [31:0] m_tx_lo, m_tx_hi;
  logic [63:0] m_rx, m_frame_tx;

  task automatic model_reset();
    m_div = 8'd3; m_lat_div = 8'd0; m_ie = 0; m_done = 0; m_err = 0; m_active = 0;
    m_tx_lo = 0; m_tx_hi = 0; m_rx = 0; m_frame_tx = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = o;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      A_CTRL: return {23'd0, m_ie, m_div};
      A_STAT: return {29'd0, m_err, m_done, m_active};
      A_TXLO: return m_tx_lo;
      A_TXHI: return m_tx_hi;
      A_RXLO: return m_rx[31:0];
      A_RXHI: return m_rx[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a)
      A_CTRL: begin
        if (s[0]) m_div = d[7:0];
        if (s[1]) m_ie = d[8];
        if (s[1] && d[9]) begin
          if (m_active) m_err = 1;
          else begin
            m_active = 1; m_lat_div = m_div; m_frame_tx = {m_tx_hi, m_tx_lo};
          end
        end
      end
      A_STAT: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      A_TXLO: if (m_active) m_err = 1; else m_tx_lo = merge(m_tx_lo, d, s);
      A_TXHI: if (m_active) m_err = 1; else m_tx_hi = merge(m_tx_hi, d, s);
      default: ;
    endcase
  endtask

  // ---------------- SPI peripheral model ----------------
  logic        loop_en = 1'b1;
  logic [63:0] slave_pat = '0, slv_sh = '0, copi_seen = '0;
  int          sck_edges = 0;

  assign spi_cipo_i = loop_en ? spi_copi_o : slv_sh[63];

  always @(negedge spi_cs_o) begin
    slv_sh = slave_pat; copi_seen = '0; sck_edges = 0;
  end
  always @(posedge spi_sck_o) begin
    copi_seen = {copi_seen[62:0], spi_copi_o};
    slv_sh    = {slv_sh[62:0], 1'b0};
  end
  always @(spi_sck_o) if (!spi_cs_o) sck_edges++;

  // ---------------- scoreboard monitor ----------------
  logic [32:0] mon_e;
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_e[32]) check("read_data", {32'd0, wbs_dat_o}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  time  t_ack, t_start;
  logic irq_at_ack;

  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input bit expect_ack);
    int n; bit got;
    n = 0; got = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    while (n < 6 && !got) begin
      @(posedge wb_clk_i); #1; n++;
      if (wbs_ack_o) got = 1;
    end
    t_ack = $time; irq_at_ack = irq_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    if (expect_ack) check("ack_latency", got ? n : 0, 1);
    else            check("no_ack_on_miss", {63'd0, got}, 0);
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_read(input logic [31:0] a);
    exp_q.push_back({1'b1, model_read(a)});
    wb_access(a, 32'd0, 4'hF, 1'b0, 1'b1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit is_start;
    is_start = (a == A_CTRL) && s[1] && d[9] && !m_active;
    exp_q.push_back({1'b0, 32'd0});
    model_write(a, d, s);
    wb_access(a, d, s, 1'b1, 1'b1);
    if (is_start) t_start = t_ack;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 0;
    @(posedge wb_clk_i); #1;
    check("rst_cs", {63'd0, spi_cs_o}, 1);
    check("rst_sck", {63'd0, spi_sck_o}, 0);
    check("rst_ack_busy_irq", {61'd0, wbs_ack_o, busy_o, irq_o}, 0);
    repeat (cycles - 1) begin @(posedge wb_clk_i); #1; end
    resetn = 1;
    model_reset();
  endtask

  // Wait for CS to rise after an accepted START and check the frame.
  task automatic wait_frame();
    int lim, lat;
    bit seen;
    lat  = (2 * N + 2) * (int'(m_lat_div) + 1) + 1;
    lim  = lat + 50;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(posedge wb_clk_i); #1;
      if (spi_cs_o) seen = 1;
    end
    if (!seen) check("frame_timeout", 0, 1);
    else begin
      check("frame_latency", int'(($time - t_start) / 10), lat);
      check("sck_edges", sck_edges, 2 * N);
      check("copi_bits", copi_seen, m_frame_tx);
      check("busy_after_cs", {63'd0, busy_o}, 0);
      check("irq_with_done", {63'd0, irq_o}, {63'd0, m_ie});
    end
    m_rx = loop_en ? m_frame_tx : slave_pat;
    m_done = 1; m_active = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks, first;
    logic [7:0] d;
    model_reset();
    do_reset(3);
    check("rst_dat_o", {32'd0, wbs_dat_o}, 0);
    wb_read(A_STAT);
    wb_read(A_CTRL);
    wb_read(A_RXLO);
    wb_read(A_RXHI);

    // Loopback, DIV=0: 131 clocks from START ack to CS high.
    loop_en = 1;
    wb_write(A_CTRL, 32'h0, 4'b0001);
    wb_write(A_TXLO, 32'h0123_4567, 4'hF);
    wb_write(A_TXHI, 32'hDEAD_BEEF, 4'hF);
    wb_write(A_CTRL, 32'h200, 4'b0010);
    check("busy_after_start", {63'd0, busy_o}, 1);
    wait_frame();
    check("loopback_latency_131", int'(($time - t_start) / 10), 131);
    wb_read(A_STAT);
    wb_read(A_RXLO);
    wb_read(A_RXHI);

    // TX write and START while busy: ERR set, TX kept, DIV latched at START.
    loop_en = 0;
    slave_pat = {$urandom, $urandom};
    wb_write(A_STAT, 32'h2, 4'b0001);
    wb_write(A_CTRL, 32'h1, 4'b0001);
    wb_write(A_TXLO, $urandom, 4'hF);
    wb_write(A_TXHI, $urandom, 4'hF);
    wb_write(A_CTRL, 32'h200, 4'b0010);
    wb_read(A_RXLO);
    wb_write(A_TXLO, $urandom, 4'hF);
    wb_write(A_CTRL, 32'h203, 4'b0011);
    wb_read(A_STAT);
    wait_frame();
    wb_read(A_TXLO);
    wb_read(A_RXLO);
    wb_read(A_RXHI);
    wb_read(A_STAT);
    wb_write(A_STAT, 32'h4, 4'b0001);
    wb_read(A_STAT);

    // Strobe held for 5 cycles yields exactly one ack, one cycle after valid.
    exp_q.push_back({1'b1, model_read(A_STAT)});
    acks = 0; first = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = A_STAT; wbs_sel_i = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin acks++; if (first == 0) first = i; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge wb_clk_i); #1;
    check("held_stb_ack_count", acks, 1);
    check("held_stb_ack_cycle", first, 1);

    // Byte-lane write, unmapped offsets and address misses.
    wb_write(A_TXLO, 32'hFFFF_FFFF, 4'b0010);
    wb_read(A_TXLO);
    wb_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h18);
    wb_read(BASE + 32'h1C);
    wb_access(BASE + 32'h20, 32'h0, 4'hF, 1'b0, 1'b0);
    wb_access(32'h2000_0000, 32'h0, 4'hF, 1'b1, 1'b0);

    // Interrupt: IE=1 frame raises irq with DONE; clearing DONE drops it.
    wb_write(A_STAT, 32'h6, 4'b0001);
    wb_write(A_CTRL, 32'h300, 4'b0011);
    check("irq_low_in_frame", {63'd0, irq_o}, 0);
    wait_frame();
    wb_write(A_STAT, 32'h2, 4'b0001);
    check("irq_falls_after_w1c", {63'd0, irq_at_ack}, 0);
    wb_read(A_STAT);

    // Randomized frames.
    for (int k = 0; k < 4; k++) begin
      loop_en   = $urandom_range(0, 1);
      slave_pat = {$urandom, $urandom};
      d = 8'($urandom_range(0, 2));
      wb_write(A_TXLO, $urandom, 4'($urandom_range(1, 15)));
      wb_write(A_TXHI, $urandom, 4'hF);
      wb_write(A_CTRL, {22'd0, 1'b1, 1'($urandom_range(0, 1)), d}, 4'b0011);
      wait_frame();
      wb_read(A_RXLO);
      wb_read(A_RXHI);
      wb_read(A_STAT);
      wb_write(A_STAT, 32'h6, 4'b0001);
    end

    // Reset in the middle of a frame.
    wb_write(A_CTRL, 32'h202, 4'b0011);
    repeat (40) begin @(posedge wb_clk_i); #1; end
    check("busy_mid_frame", {63'd0, busy_o}, 1);
    do_reset(2);
    wb_read(A_RXLO);
    wb_read(A_CTRL);
    wb_read(A_STAT);

    repeat (3) begin @(posedge wb_clk_i); #1; end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
